// File: rtl/simt_scheduler.sv
// simt_scheduler: per-lane PC sequencer that issues the minimum-PC thread group each instruction.
// Lanes that reach the same PC always issue together, which is how diverged threads reconverge.
module simt_scheduler #(
    parameter int unsigned THREADS_PER_BLOCK = 4,
    parameter int unsigned PC_BITS           = 8,
    parameter int unsigned COUNT_BITS        = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [$clog2(THREADS_PER_BLOCK):0]   thread_count,
    input  logic                                 fetch_done,
    input  logic                                 decoded_ret,
    input  logic [THREADS_PER_BLOCK-1:0]         lsu_busy,
    input  logic [THREADS_PER_BLOCK*PC_BITS-1:0] next_pc,
    output logic [2:0]                           core_state,
    output logic [PC_BITS-1:0]                   current_pc,
    output logic [THREADS_PER_BLOCK-1:0]         active_mask,
    output logic                                 done,
    output logic [COUNT_BITS-1:0]                instr_count
);
    localparam int unsigned T  = THREADS_PER_BLOCK;
    localparam int unsigned CW = $clog2(THREADS_PER_BLOCK) + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        REQUEST = 3'd3,
        WAIT    = 3'd4,
        EXECUTE = 3'd5,
        UPDATE  = 3'd6,
        DONE    = 3'd7
    } state_t;

    state_t             state, state_next;
    logic [PC_BITS-1:0] thread_pc [T];
    logic [PC_BITS-1:0] upd_pc    [T];
    logic [T-1:0]       thread_done, enabled, en_mask;
    logic [T-1:0]       upd_done, live, group;
    logic [CW-1:0]      count_clamped;
    logic [PC_BITS-1:0] min_pc;

    assign core_state = state;

    always_comb begin
        count_clamped = (thread_count > CW'(T)) ? CW'(T) : thread_count;
        en_mask = '0;
        for (int unsigned i = 0; i < T; i++) begin
            en_mask[i] = (i < 32'(count_clamped));
        end
    end

    // Post-UPDATE lane view: the next group is chosen from PCs as they will be after this edge.
    always_comb begin
        upd_done = thread_done;
        live     = '0;
        group    = '0;
        min_pc   = '1;
        for (int unsigned i = 0; i < T; i++) begin
            upd_pc[i] = thread_pc[i];
            if (active_mask[i]) begin
                if (decoded_ret) begin
                    upd_done[i] = 1'b1;
                end else begin
                    upd_pc[i] = next_pc[i*PC_BITS +: PC_BITS];
                end
            end
        end
        for (int unsigned i = 0; i < T; i++) begin
            live[i] = enabled[i] & ~upd_done[i];
            if (live[i] && (upd_pc[i] < min_pc)) begin
                min_pc = upd_pc[i];
            end
        end
        for (int unsigned i = 0; i < T; i++) begin
            group[i] = live[i] && (upd_pc[i] == min_pc);
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = (count_clamped == '0) ? DONE : FETCH;
            FETCH:   if (fetch_done) state_next = DECODE;
            DECODE:  state_next = REQUEST;
            REQUEST: state_next = WAIT;
            WAIT:    if ((lsu_busy & active_mask) == '0) state_next = EXECUTE;
            EXECUTE: state_next = UPDATE;
            UPDATE:  state_next = (live == '0) ? DONE : FETCH;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            current_pc  <= '0;
            active_mask <= '0;
            done        <= 1'b0;
            instr_count <= '0;
            thread_done <= '0;
            enabled     <= '0;
            for (int unsigned i = 0; i < T; i++) begin
                thread_pc[i] <= '0;
            end
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int unsigned i = 0; i < T; i++) begin
                            thread_pc[i] <= '0;
                        end
                        thread_done <= '0;
                        instr_count <= '0;
                        enabled     <= en_mask;
                        current_pc  <= '0;
                        if (count_clamped == '0) begin
                            done <= 1'b1;
                        end else begin
                            active_mask <= en_mask;
                        end
                    end
                end
                UPDATE: begin
                    for (int unsigned i = 0; i < T; i++) begin
                        thread_pc[i] <= upd_pc[i];
                    end
                    thread_done <= upd_done;
                    instr_count <= instr_count + COUNT_BITS'(1);
                    if (live == '0) begin
                        done <= 1'b1;
                    end else begin
                        current_pc  <= min_pc;
                        active_mask <= group;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_simt_scheduler.sv
// Bench for simt_scheduler: directed scenarios plus randomized programs, checked every cycle
// against a lane-level model of the scheduling rules.
module tb_simt_scheduler;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  thread_count = '0;
    logic        fetch_done = 1'b0;
    logic        decoded_ret = 1'b0;
    logic [3:0]  lsu_busy = '0;
    logic [31:0] next_pc = '0;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic [3:0]  active_mask;
    logic        done;
    logic [15:0] instr_count;

    simt_scheduler #(.THREADS_PER_BLOCK(4), .PC_BITS(8), .COUNT_BITS(16)) dut (
        .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
        .fetch_done(fetch_done), .decoded_ret(decoded_ret), .lsu_busy(lsu_busy),
        .next_pc(next_pc), .core_state(core_state), .current_pc(current_pc),
        .active_mask(active_mask), .done(done), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Program: per-PC RET flag and per-lane successor PC.
    bit         ret_at [256];
    logic [7:0] nxt [T][256];

    // Model state
    int          m_state;
    logic [7:0]  m_pc [T];
    bit          m_tdone [T];
    bit          m_en [T];
    logic [7:0]  m_cur;
    logic [3:0]  m_mask;
    bit          m_done;
    logic [15:0] m_cnt;

    // Stimulus knobs
    int         lsu_mode = 0;
    logic [3:0] lsu_fixed = '0;
    bit         stall_rand = 0;
    bit         start_noise = 0;
    bit         hold_start = 0;
    int         wait_seen = 0;
    int         ncyc = 0;

    logic [7:0] lg_pc [$];
    logic [3:0] lg_mask [$];
    bit         lg_done [$];
    logic [2:0] prev_state = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cur = '0; m_mask = '0; m_done = 0; m_cnt = '0;
        for (int l = 0; l < T; l++) begin
            m_pc[l] = '0; m_tdone[l] = 0; m_en[l] = 0;
        end
    endtask

    task automatic model_step();
        int n;
        int live [$];
        logic [7:0] lo;
        case (m_state)
            0: if (start) begin
                n = (thread_count > 3'd4) ? 4 : int'(thread_count);
                m_cnt = '0; m_cur = '0;
                for (int l = 0; l < T; l++) begin
                    m_pc[l] = '0; m_tdone[l] = 0; m_en[l] = (l < n);
                end
                if (n == 0) begin
                    m_done = 1; m_state = 7;
                end else begin
                    m_mask = 4'((1 << n) - 1); m_state = 1;
                end
            end
            1: if (fetch_done) m_state = 2;
            2: m_state = 3;
            3: m_state = 4;
            4: if ((lsu_busy & m_mask) == 4'b0) m_state = 5;
            5: m_state = 6;
            6: begin
                for (int l = 0; l < T; l++) begin
                    if (m_mask[l]) begin
                        if (decoded_ret) m_tdone[l] = 1;
                        else m_pc[l] = next_pc[l*8 +: 8];
                    end
                end
                m_cnt = m_cnt + 16'd1;
                for (int l = 0; l < T; l++) if (m_en[l] && !m_tdone[l]) live.push_back(l);
                if (live.size() == 0) begin
                    m_done = 1; m_state = 7;
                end else begin
                    lo = m_pc[live[0]];
                    foreach (live[k]) if (m_pc[live[k]] < lo) lo = m_pc[live[k]];
                    m_cur = lo; m_mask = '0;
                    foreach (live[k]) if (m_pc[live[k]] == lo) m_mask[live[k]] = 1'b1;
                    m_state = 1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare();
        check("core_state", 32'(core_state), 32'(m_state));
        check("current_pc", 32'(current_pc), 32'(m_cur));
        check("active_mask", 32'(active_mask), 32'(m_mask));
        check("done", 32'(done), 32'(m_done));
        check("instr_count", 32'(instr_count), 32'(m_cnt));
        if (core_state == 3'd1 && prev_state != 3'd1) begin
            lg_pc.push_back(current_pc); lg_mask.push_back(active_mask); lg_done.push_back(done);
        end
        prev_state = core_state;
    endtask

    task automatic drive_inputs();
        start = hold_start ? 1'b1 : (start_noise ? ($urandom_range(0, 7) == 0) : 1'b0);
        fetch_done = stall_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        case (lsu_mode)
            1: lsu_busy = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            2: lsu_busy = lsu_fixed;
            3: lsu_busy = (m_state == 4 && wait_seen < 5) ? 4'b0010 : 4'b0000;
            default: lsu_busy = 4'b0;
        endcase
        if (m_state == 5 || m_state == 6) begin
            decoded_ret = ret_at[m_cur];
            for (int l = 0; l < T; l++) next_pc[l*8 +: 8] = nxt[l][m_cur];
        end else begin
            decoded_ret = 1'($urandom_range(0, 1));
            next_pc = $urandom;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (m_state == 4) wait_seen++;
        if (reset) model_reset(); else model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1 model_reset();
        compare();
        @(negedge clk);
        compare();
        reset = 1'b0; start = 1'b0;
    endtask

    task automatic run_block(input int cnt, input int budget);
        lg_pc.delete(); lg_mask.delete(); lg_done.delete();
        wait_seen = 0;
        thread_count = 3'(cnt);
        drive_inputs();
        start = 1'b1;
        tick();
        ncyc = 0;
        while (done !== 1'b1 && ncyc < budget) begin
            drive_inputs(); tick(); ncyc++;
        end
        check("run_finished", 32'(done), 32'd1);
        for (int k = 0; k < 2; k++) begin
            drive_inputs(); start = 1'b1; tick();
        end
    endtask

    task automatic prog_linear(input int ret_pc);
        for (int p = 0; p < 256; p++) begin
            ret_at[p] = (p == ret_pc);
            for (int l = 0; l < T; l++) nxt[l][p] = 8'(p + 1);
        end
    endtask

    task automatic prog_random();
        int base;
        for (int p = 0; p < 256; p++) begin
            ret_at[p] = (p >= 12) || (p > 0 && $urandom_range(0, 5) == 0);
            base = p + 1 + $urandom_range(0, 2);
            for (int l = 0; l < T; l++)
                nxt[l][p] = 8'(($urandom_range(0, 2) == 0) ? base + $urandom_range(1, 3) : base);
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        compare();
        check("rst_state", 32'(core_state), 32'd0);
        check("rst_mask", 32'(active_mask), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);
        reset = 1'b0;

        // Uniform flow, start held high throughout.
        prog_linear(3); lsu_mode = 0; hold_start = 1;
        run_block(4, 200);
        hold_start = 0;
        check("uniform_cycles", 32'(ncyc), 32'd24);
        check("uniform_count", 32'(instr_count), 32'd4);
        check("uniform_groups", 32'(lg_pc.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check("uniform_pc", 32'(lg_pc[k]), 32'(k));
            check("uniform_mask", 32'(lg_mask[k]), 32'hF);
        end
        do_reset();

        // Divergence at pc 2, reconvergence at pc 9.
        prog_linear(9);
        nxt[0][2] = 8'd5; nxt[1][2] = 8'd5; nxt[2][2] = 8'd9; nxt[3][2] = 8'd9;
        for (int l = 0; l < T; l++) nxt[l][5] = 8'd9;
        run_block(4, 200);
        check("div_groups", 32'(lg_pc.size()), 32'd5);
        check("div_pc3", 32'(lg_pc[3]), 32'd5);
        check("div_mask3", 32'(lg_mask[3]), 32'b0011);
        check("div_pc4", 32'(lg_pc[4]), 32'd9);
        check("div_mask4", 32'(lg_mask[4]), 32'b1111);
        check("div_count", 32'(instr_count), 32'd5);
        do_reset();

        // Partial block; lane 3 busy must not stall.
        prog_linear(3); lsu_mode = 2; lsu_fixed = 4'b1000;
        run_block(3, 200);
        check("part3_mask", 32'(lg_mask[0]), 32'b0111);
        check("part3_cycles", 32'(ncyc), 32'd24);
        do_reset();
        lsu_mode = 0;
        run_block(7, 200);
        check("part7_mask", 32'(lg_mask[0]), 32'b1111);
        check("part7_cycles", 32'(ncyc), 32'd24);
        do_reset();

        // LSU stall: lane 1 busy for 5 WAIT cycles on a one-instruction program.
        prog_linear(0); lsu_mode = 3;
        run_block(4, 200);
        check("stall_cycles", 32'(ncyc), 32'd11);
        lsu_mode = 0;
        do_reset();

        // Zero-count block.
        run_block(0, 5);
        check("count0_cycles", 32'(ncyc), 32'd0);
        check("count0_state", 32'(core_state), 32'd7);
        check("count0_instr", 32'(instr_count), 32'd0);
        do_reset();

        // Split RET at different PCs.
        prog_linear(255);
        nxt[0][0] = 8'd4; nxt[1][0] = 8'd4; nxt[2][0] = 8'd6; nxt[3][0] = 8'd6;
        ret_at[4] = 1; ret_at[6] = 1;
        run_block(4, 200);
        check("split_groups", 32'(lg_pc.size()), 32'd3);
        check("split_mask1", 32'(lg_mask[1]), 32'b0011);
        check("split_pc2", 32'(lg_pc[2]), 32'd6);
        check("split_mask2", 32'(lg_mask[2]), 32'b1100);
        check("split_done_early", 32'(lg_done[2]), 32'd0);
        check("split_count", 32'(instr_count), 32'd3);
        do_reset();

        // Reset while stuck in WAIT, then a clean rerun.
        prog_linear(3); lsu_mode = 2; lsu_fixed = 4'b1111; wait_seen = 0;
        thread_count = 3'd4;
        drive_inputs(); start = 1'b1; tick();
        for (int k = 0; k < 20 && !(m_state == 4 && wait_seen >= 3); k++) begin
            drive_inputs(); tick();
        end
        check("pre_rst_wait", 32'(core_state), 32'd4);
        #2 reset = 1'b1;
        #1 model_reset();
        check("arst_state", 32'(core_state), 32'd0);
        check("arst_mask", 32'(active_mask), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_count", 32'(instr_count), 32'd0);
        compare();
        @(negedge clk);
        reset = 1'b0; start = 1'b0; lsu_mode = 0;
        run_block(4, 200);
        check("rerun_pc0", 32'(lg_pc[0]), 32'd0);
        check("rerun_count", 32'(instr_count), 32'd4);
        check("rerun_cycles", 32'(ncyc), 32'd24);
        do_reset();

        // Randomized programs, stalls and stray start pulses.
        for (int r = 0; r < 40; r++) begin
            prog_random();
            lsu_mode = 1; stall_rand = 1; start_noise = 1;
            run_block($urandom_range(0, 7), 3000);
            do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/simt_scheduler.md
# simt_scheduler

Per-core control sequencer for divergent SIMT execution. It is the next generation of the compute core's scheduler: it keeps a separate PC for every thread instead of one shared PC, and issues the minimum-PC thread group each instruction under an active mask. Threads reconverge automatically when their PCs become equal again. It sits between the fetcher/decoder and the per-thread ALU/LSU/register/PC lanes, which must gate their work with `active_mask`.

## Interface
- `THREADS_PER_BLOCK`, 4: lanes per core (≥1).
- `PC_BITS`, 8: program-counter width.
- `COUNT_BITS`, 16: width of the retired-instruction counter.

- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: launch block; sampled only in IDLE.
- `thread_count` in $clog2(THREADS_PER_BLOCK)+1: enabled lanes; values above THREADS_PER_BLOCK are clamped to it.
- `fetch_done` in 1: fetcher has the instruction at `current_pc`; sampled in FETCH.
- `decoded_ret` in 1: decoded instruction is RET; valid from EXECUTE onward.
- `lsu_busy` in THREADS_PER_BLOCK: per-lane LSU still has an outstanding request.
- `next_pc` in THREADS_PER_BLOCK*PC_BITS: per-lane computed next PC, lane i at bits [i*PC_BITS +: PC_BITS]; valid in UPDATE.
- `core_state` out 3: IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7.
- `current_pc` out PC_BITS: PC of the issuing group.
- `active_mask` out THREADS_PER_BLOCK: lanes executing the current instruction.
- `done` out 1: block finished; sticky until reset.
- `instr_count` out COUNT_BITS: instructions retired (UPDATE visits); wraps at 2^COUNT_BITS.

## Operation
- Internal state per lane: `thread_pc[i]` (PC_BITS) and `thread_done[i]`.
- A lane is enabled when i < clamped `thread_count`. A lane is live when it is enabled and `thread_done[i]` is 0.
- Group selection: `min_pc` is the minimum `thread_pc` over live lanes. The next group is every live lane with `thread_pc == min_pc`. Equal PCs are always grouped together; this is the reconvergence rule.
- State transitions:
  - IDLE: on `start`, clear all `thread_pc` to 0, clear all `thread_done`, and clear `instr_count`.
    - If the clamped count is 0: go to DONE.
    - Otherwise: set `current_pc`=0, set `active_mask` to the enabled lanes, go to FETCH.
  - FETCH: stay until `fetch_done`=1, then go to DECODE.
  - DECODE: 1 cycle, then REQUEST.
  - REQUEST: 1 cycle, then WAIT. LSUs issue during this state.
  - WAIT: go to EXECUTE in the first cycle where `(lsu_busy & active_mask)==0`; otherwise stay. Busy bits of inactive lanes are ignored.
  - EXECUTE: 1 cycle, then UPDATE.
  - UPDATE: for each active lane, if `decoded_ret` set `thread_done[i]`, else load `thread_pc[i]` ← `next_pc` slice. Increment `instr_count`. Then:
    - If no lane remains live: go to DONE.
    - Otherwise: register the new group (`current_pc`=min_pc over the updated PCs, `active_mask`), go to FETCH.
  - DONE: `done`=1. Hold indefinitely; `start` is ignored.
- `start` in any state other than IDLE has no effect.
- Inactive lanes never change `thread_pc` or `thread_done`.
- PCs are unsigned. There is no wrap protection: `next_pc` is taken verbatim.

## Timing
- Reset values: `core_state`=IDLE, `current_pc`=0, `active_mask`=0, `done`=0, `instr_count`=0, all `thread_pc`=0, all `thread_done`=0.
- Reset asserted in any state returns the block to IDLE immediately (asynchronously) and discards any in-flight instruction.
- All outputs are registered. `active_mask` and `current_pc` change only on the IDLE→FETCH and UPDATE→FETCH edges and are stable from FETCH through UPDATE.
- Minimum instruction cost: 6 cycles (FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE), each extra `fetch_done`-low cycle adds 1, and each extra `lsu_busy` cycle adds 1.
- `start` seen in IDLE at edge t gives `core_state`=FETCH after t.
- `done` rises on the edge that leaves UPDATE with no live lanes, or on the edge leaving IDLE when the clamped count is 0.

## Test plan
- Uniform flow: T=4, count=4, `fetch_done` and `lsu_busy` tied so there are no stalls. `next_pc`=pc+1 for 3 instructions, then `decoded_ret`. Required: mask stays 1111, `current_pc` goes 0,1,2,3, `done` is high after 24 cycles, `instr_count`=4.
- Divergence and reconvergence: at pc 2, lanes 0–1 get `next_pc`=5 and lanes 2–3 get 9.
  - Required: next group is pc=5 with mask 0011. Lanes 0–1 then step 5→9, after which pc=9 with mask 1111.
- Partial block: count=3, and again with count=7 (clamped to 4). Required: mask 0111 for count=3 and mask 1111 for count=7. Lane 3 `lsu_busy`=1 held in WAIT must not stall the count=3 run.
- LSU stall: lane 1 `lsu_busy` high for 5 cycles after REQUEST. Required: WAIT holds 5 cycles and EXECUTE follows on the first cycle where the bit is 0.
- Edge cases:
  - count=0 plus `start`: DONE with `instr_count`=0 on the next cycle.
  - `start` pulsed mid-run: no effect.
  - Split RET: lanes with RET at different PCs finish independently, and `done` rises only after the last one.
- Reset mid-WAIT with `lsu_busy` high: `core_state`=IDLE, and `active_mask`=0, `done`=0, `instr_count`=0 immediately. A fresh `start` then runs cleanly from pc 0.
